muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit; parametrised in `XLEN`.
- Sits beside the single-cycle ALU in the execute stage. The execute stage steers M-extension instructions (opcode 0110011, funct7 0000001) to it.
- Uses the pipeline's valid/ready/stall handshake. Holds the execute stage busy for the multi-cycle operation and returns one result per accepted instruction.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/muldiv_datapath.sv | 163 ++++++++++++++++
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V constants: the opcode/funct7 pair that steers
//               M-extension instructions, the funct3 encodings of the eight
//               multiply/divide operations and the muldiv_unit state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_datapath
// Description : Datapath of the iterative multiply/divide unit. Holds a
//               2*XLEN accumulator, the operand magnitude and the result
//               sign; performs one shift-add (multiply) or one restoring
//               divide step per i_step strobe and the final sign correction
//               and half/quotient/remainder select on i_fix.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_load         - latch operation and operands
//               i_step         - perform one iteration
//               i_fix          - compute and register the final result
//               i_funct3       - operation select (valid with i_load)
//               i_a, i_b       - rs1 / rs2 operands (valid with i_load)
//               o_special      - divide-by-zero or signed-overflow case
//               o_res          - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_fix,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_special,
    output logic [XLEN-1:0] o_res
);

    localparam logic [XLEN-1:0] C_ALL_ONES = '1;
    localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic              neg_q, neg_d;
    logic [2:0]        f3_q,  f3_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Operand decode at accept
    logic              w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic              w_div0, w_ovf, w_neg;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [2*XLEN-1:0] w_acc_init;

    always_comb begin
        w_is_div   = i_funct3[2];
        w_a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU) ||
                     (i_funct3 == F3_DIV)  || (i_funct3 == F3_REM);
        w_b_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_DIV) ||
                     (i_funct3 == F3_REM);
        w_sa       = w_a_signed && i_a[XLEN-1];
        w_sb       = w_b_signed && i_b[XLEN-1];
        w_mag_a    = w_sa ? (~i_a + 1'b1) : i_a;
        w_mag_b    = w_sb ? (~i_b + 1'b1) : i_b;
        w_div0     = w_is_div && (i_b == '0);
        w_ovf      = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                     (i_a == C_INT_MIN) && (i_b == C_ALL_ONES);

        // Remainder follows the dividend's sign; product and quotient take
        // the XOR of the operand signs. A divide-by-zero quotient is the
        // unsigned all-ones pattern, so it must never be negated.
        if (w_is_div && i_funct3[1]) begin
            w_neg = w_sa;
        end else begin
            w_neg = (w_sa ^ w_sb) && !w_div0;
        end

        // Special cases skip the iterations, so the accumulator is preloaded
        // with the final {remainder, quotient}. Overflow needs no special
        // preload: quotient |A| = 2^(XLEN-1) with positive sign and a zero
        // remainder is exactly the required answer.
        if (!w_is_div) begin
            w_acc_init = {{XLEN{1'b0}}, w_mag_b};
        end else if (w_div0) begin
            w_acc_init = {w_mag_a, C_ALL_ONES};
        end else begin
            w_acc_init = {{XLEN{1'b0}}, w_mag_a};
        end
    end

    assign o_special = w_div0 || w_ovf;

    // One iteration of each algorithm
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_div_next;

    always_comb begin
        // Shift-add: multiplier sits in the low half and is consumed LSB
        // first; the carry out of the add re-enters at the top on the shift.
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: the shifted partial remainder can be XLEN+1 bits
        // wide, so the trial subtraction is done at that width.
        w_trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
        w_div_next = w_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_qr, w_qr_s, w_res;

    always_comb begin
        w_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        w_qr   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        w_qr_s = neg_q ? (~w_qr + 1'b1) : w_qr;
        if (f3_q[2]) begin
            w_res = w_qr_s;
        end else if (f3_q == F3_MUL) begin
            w_res = w_prod[XLEN-1:0];
        end else begin
            w_res = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        acc_d = acc_q;
        opd_d = opd_q;
        neg_d = neg_q;
        f3_d  = f3_q;
        res_d = res_q;
        if (i_load) begin
            acc_d = w_acc_init;
            opd_d = w_is_div ? w_mag_b : w_mag_a;
            neg_d = w_neg;
            f3_d  = i_funct3;
        end else if (i_step) begin
            acc_d = f3_q[2] ? w_div_next : w_mul_next;
        end else if (i_fix) begin
            res_d = w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            opd_q <= '0;
            neg_q <= 1'b0;
            f3_q  <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            opd_q <= opd_d;
            neg_q <= neg_d;
            f3_q  <= f3_d;
            res_q <= res_d;
        end
    end

    assign o_res = res_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit for the execute
//               stage. One bit per cycle; FSM, iteration counter and the
//               valid/ready/stall handshake live here, arithmetic lives in
//               muldiv_datapath.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               IR        - instruction (funct3 = IR[14:12] decoded)
//               A, B      - rs1 / rs2 operands
//               v_in      - upstream valid;   r_out - ready to upstream
//               v_out     - result valid;     r_in  - downstream ready
//               stall     - global pipeline freeze
//               IR_res    - registered IR of the accepted instruction
//               res       - registered result for rd
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IR,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            v_in,
    output logic            r_out,
    output logic            v_out,
    input  logic            r_in,
    input  logic            stall,
    output logic [31:0]     IR_res,
    output logic [XLEN-1:0] res
);

    localparam int             CW         = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(XLEN);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   ir_q,    ir_d;
    logic          v_out_q, v_out_d;

    logic          w_load, w_step, w_fix, w_special;

    // No path from v_in: readiness depends only on state and stall.
    assign r_out = (state_q == ST_IDLE) && !stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_fix   = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (v_in) begin
                        w_load  = 1'b1;
                        ir_d    = IR;
                        cnt_d   = '0;
                        // Special cases carry a preloaded result and only
                        // need the single correction/select cycle.
                        state_d = w_special ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == C_CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        w_step = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    w_fix   = 1'b1;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (r_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        v_out_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ir_q    <= '0;
            v_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            v_out_q <= v_out_d;
        end
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_fix     (w_fix),
        .i_funct3  (IR[14:12]),
        .i_a       (A),
        .i_b       (B),
        .o_special (w_special),
        .o_res     (res)
    );

    assign v_out  = v_out_q;
    assign IR_res = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (XLEN = 32). Directed
//               cases with hand-derived answers, handshake/stall/reset
//               scenarios and randomized operations checked against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     IR  = '0;
    logic [XLEN-1:0] A   = '0;
    logic [XLEN-1:0] B   = '0;
    logic            v_in  = 1'b0;
    logic            r_out;
    logic            v_out;
    logic            r_in  = 1'b0;
    logic            stall = 1'b0;
    logic [31:0]     IR_res;
    logic [XLEN-1:0] res;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .IR     (IR),
        .A      (A),
        .B      (B),
        .v_in   (v_in),
        .r_out  (r_out),
        .v_out  (v_out),
        .r_in   (r_in),
        .stall  (stall),
        .IR_res (IR_res),
        .res    (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the RISC-V M-extension definitions.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = ua * ub;                return p[31:0];  end
            3'd1: begin p = 64'(sa * sb);           return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub;                return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [2:0] f3);
        logic [14:0] regs;
        regs = 15'($urandom);
        return {7'b0000001, regs[14:10], regs[9:5], f3, regs[4:0], 7'b0110011};
    endfunction

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] ir);
        @(negedge clk);
        ir   = mk_ir(f3);
        IR   = ir;
        A    = a;
        B    = b;
        v_in = 1'b1;
        @(posedge clk);
        #1;
        t0   = cyc;
        v_in = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        while (!v_out && (cyc - t0) < 200) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - t0;
    endtask

    task automatic ack();
        @(negedge clk);
        r_in = 1'b1;
        @(posedge clk);
        #1;
        r_in = 1'b0;
        chk("ack_ready", 64'(r_out), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        logic [31:0] ir;
        int          lat;
        start_op(f3, a, b, ir);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_res"}, 64'(res), 64'(exp));
        chk({tag, "_ir"},  64'(IR_res), 64'(ir));
        ack();
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [31:0] ir, a, b;
        logic [2:0]  f3;
        int          lat;

        dir.push_back('{"mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        dir.push_back('{"mulh",     3'd1, INT_MIN,      INT_MIN,       32'h4000_0000, 34});
        dir.push_back('{"mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        dir.push_back('{"mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        dir.push_back('{"divu",     3'd5, 32'd100,      32'd7,         32'd14,        34});
        dir.push_back('{"remu",     3'd7, 32'd100,      32'd7,         32'd2,         34});
        dir.push_back('{"div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34});
        dir.push_back('{"rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34});
        dir.push_back('{"rem_negb", 3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,         34});
        dir.push_back('{"div_by0",  3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF, 1});
        dir.push_back('{"rem_by0",  3'd6, 32'd5,        32'd0,         32'd5,         1});
        dir.push_back('{"divu_by0", 3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 1});
        dir.push_back('{"div_ovf",  3'd4, INT_MIN,      32'hFFFF_FFFF, INT_MIN,       1});
        dir.push_back('{"rem_ovf",  3'd6, INT_MIN,      32'hFFFF_FFFF, 32'd0,         1});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vout",  64'(v_out),  64'd0);
        chk("rst_res",   64'(res),    64'd0);
        chk("rst_ir",    64'(IR_res), 64'd0);
        chk("rst_ready", 64'(r_out),  64'd1);

        foreach (dir[i])
            do_op(dir[i].tag, dir[i].f3, dir[i].a, dir[i].b, dir[i].exp, dir[i].lat);

        // Downstream back-pressure in DONE with a competing upstream request
        start_op(3'd5, 32'd100, 32'd7, ir);
        wait_done(lat);
        chk("hold_lat", 64'(lat), 64'd34);
        @(negedge clk);
        IR   = mk_ir(3'd0);
        A    = 32'd9;
        B    = 32'd9;
        v_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_vout",  64'(v_out),  64'd1);
            chk("hold_res",   64'(res),    64'd14);
            chk("hold_ir",    64'(IR_res), 64'(ir));
            chk("hold_ready", 64'(r_out),  64'd0);
        end
        v_in = 1'b0;
        ack();
        do_op("after_hold", 3'd0, 32'd9, 32'd9, 32'd81, 34);

        // Stall for 3 cycles in the middle of CALC
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, ir);
        repeat (10) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_done(lat);
        chk("stall_lat", 64'(lat), 64'd37);
        chk("stall_res", 64'(res), 64'hFFFF_FFEB);
        ack();

        // Stall in IDLE blocks acceptance
        @(negedge clk);
        stall = 1'b1;
        IR    = mk_ir(3'd0);
        A     = 32'd2;
        B     = 32'd2;
        v_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_stall_ready", 64'(r_out), 64'd0);
        end
        stall = 1'b0;
        v_in  = 1'b0;
        @(negedge clk);
        chk("idle_stall_noacc", 64'(r_out), 64'd1);
        chk("idle_stall_vout",  64'(v_out), 64'd0);

        // Reset in the middle of a divide
        start_op(3'd4, 32'd1000, 32'd3, ir);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_vout", 64'(v_out),  64'd0);
        chk("midrst_res",  64'(res),    64'd0);
        chk("midrst_ir",   64'(IR_res), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 64'(r_out), 64'd1);
        do_op("post_rst_mul", 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // Randomized operations against the reference model
        for (int k = 0; k < 60; k++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = INT_MIN;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op("rand", f3, a, b, model(f3, a, b), exp_lat(f3, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
